// File: rtl/cpu_ctrl_fsm_if.sv
// Handshake bundle between the multi-cycle controller and the decoder/datapath.
// The master side is the controller; the slave side is the decoder/datapath.
interface cpu_ctrl_fsm_if;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w;
    logic [1:0] nsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic       write;
    logic       halted;

    modport master (
        input  s, opcode, op,
        output w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, halted
    );

    modport slave (
        output s, opcode, op,
        input  w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, halted
    );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle controller for the simple RISC datapath: sequences one MOV/ALU
// instruction per start pulse and drives Moore-style strobes and selects.
module cpu_ctrl_fsm #(
    parameter int STATE_W      = 4,
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    cpu_ctrl_fsm_if.master bus
);

    localparam logic [STATE_W-1:0] S_WAIT   = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_WR_IMM = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_GET_A  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_GET_B  = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_ALU    = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_ALU_S  = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_WR_REG = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_HALT   = STATE_W'(8);

    typedef enum logic [2:0] {
        C_ILL, C_MOV_IMM, C_MOV_REG, C_ADD, C_CMP, C_AND, C_MVN
    } cls_t;

    logic [STATE_W-1:0] state_q, state_d;
    cls_t               class_q, class_d;

    function automatic cls_t classify(input logic [2:0] opc, input logic [1:0] o);
        cls_t c;
        c = C_ILL;
        case (opc)
            3'b110: begin
                case (o)
                    2'b10:   c = C_MOV_IMM;
                    2'b00:   c = C_MOV_REG;
                    default: c = C_ILL;
                endcase
            end
            3'b101: begin
                case (o)
                    2'b00:   c = C_ADD;
                    2'b01:   c = C_CMP;
                    2'b10:   c = C_AND;
                    default: c = C_MVN;
                endcase
            end
            default: c = C_ILL;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
            class_q <= C_ILL;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
        end
    end

    // Decoder inputs are only looked at in DECODE; later states use class_q.
    always_comb begin
        state_d = S_WAIT;
        class_d = class_q;
        case (state_q)
            S_WAIT:   state_d = bus.s ? S_DECODE : S_WAIT;
            S_DECODE: begin
                class_d = classify(bus.opcode, bus.op);
                case (class_d)
                    C_MOV_IMM:                 state_d = S_WR_IMM;
                    C_MOV_REG, C_MVN:          state_d = S_GET_B;
                    C_ADD, C_AND, C_CMP:       state_d = S_GET_A;
                    default:                   state_d = ILLEGAL_TRAP ? S_HALT : S_WAIT;
                endcase
            end
            S_WR_IMM: state_d = S_WAIT;
            S_GET_A:  state_d = S_GET_B;
            S_GET_B:  state_d = (class_q == C_CMP) ? S_ALU_S : S_ALU;
            S_ALU:    state_d = S_WR_REG;
            S_ALU_S:  state_d = S_WAIT;
            S_WR_REG: state_d = S_WAIT;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_WAIT;
        endcase
    end

    always_comb begin
        bus.w      = 1'b0;
        bus.nsel   = 2'b00;
        bus.loada  = 1'b0;
        bus.loadb  = 1'b0;
        bus.loadc  = 1'b0;
        bus.loads  = 1'b0;
        bus.asel   = 1'b0;
        bus.bsel   = 1'b0;
        bus.vsel   = 2'b00;
        bus.write  = 1'b0;
        bus.halted = 1'b0;
        case (state_q)
            S_WAIT:   bus.w = 1'b1;
            S_WR_IMM: begin
                bus.nsel  = 2'b10;
                bus.vsel  = 2'b10;
                bus.write = 1'b1;
            end
            S_GET_A: begin
                bus.nsel  = 2'b10;
                bus.loada = 1'b1;
            end
            S_GET_B:  bus.loadb = 1'b1;
            S_ALU: begin
                bus.loadc = 1'b1;
                // MOV reg passes B through the adder with A forced to zero.
                bus.asel  = (class_q == C_MOV_REG);
            end
            S_ALU_S:  bus.loads = 1'b1;
            S_WR_REG: begin
                bus.nsel  = 2'b01;
                bus.write = 1'b1;
            end
            S_HALT:   bus.halted = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: two instances (illegal-op return and
// illegal-op trap) share clock, reset and stimulus.
module tb_cpu_ctrl_fsm;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    cpu_ctrl_fsm_if bus1 ();
    cpu_ctrl_fsm_if bus2 ();

    cpu_ctrl_fsm #(.STATE_W(4), .ILLEGAL_TRAP(1'b0)) dut_ret  (.clk(clk), .rst_n(rst_n), .bus(bus1));
    cpu_ctrl_fsm #(.STATE_W(4), .ILLEGAL_TRAP(1'b1)) dut_trap (.clk(clk), .rst_n(rst_n), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] q1[$];
    logic [15:0] q2[$];

    // {pad, w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, halted}
    function automatic logic [15:0] mk(input bit w, input logic [1:0] ns, input bit la, input bit lb,
                                       input bit lc, input bit ls, input bit as, input logic [1:0] vs,
                                       input bit wr, input bit h);
        return {3'b000, w, ns, la, lb, lc, ls, as, 1'b0, vs, wr, h};
    endfunction

    function automatic logic [15:0] obs1();
        return {3'b000, bus1.w, bus1.nsel, bus1.loada, bus1.loadb, bus1.loadc, bus1.loads,
                bus1.asel, bus1.bsel, bus1.vsel, bus1.write, bus1.halted};
    endfunction

    function automatic logic [15:0] obs2();
        return {3'b000, bus2.w, bus2.nsel, bus2.loada, bus2.loadb, bus2.loadc, bus2.loads,
                bus2.asel, bus2.bsel, bus2.vsel, bus2.write, bus2.halted};
    endfunction

    logic [15:0] e_wait, e_dec, e_wrimm, e_geta, e_getb, e_alu, e_alu_mov, e_alus, e_wrreg, e_halt;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %04h expected %04h", tag, got, exp);
    endtask

    task automatic push_both(input logic [15:0] v);
        q1.push_back(v);
        q2.push_back(v);
    endtask

    // Expected per-edge output vectors for one instruction, ending in WAIT/HALT.
    task automatic push_seq(input logic [2:0] opc, input logic [1:0] o);
        push_both(e_dec);
        if (opc == 3'b110 && o == 2'b10) begin
            push_both(e_wrimm);
            push_both(e_wait);
        end else if (opc == 3'b110 && o == 2'b00) begin
            push_both(e_getb); push_both(e_alu_mov); push_both(e_wrreg); push_both(e_wait);
        end else if (opc == 3'b101 && o == 2'b11) begin
            push_both(e_getb); push_both(e_alu); push_both(e_wrreg); push_both(e_wait);
        end else if (opc == 3'b101 && o == 2'b01) begin
            push_both(e_geta); push_both(e_getb); push_both(e_alus); push_both(e_wait);
        end else if (opc == 3'b101) begin
            push_both(e_geta); push_both(e_getb); push_both(e_alu); push_both(e_wrreg); push_both(e_wait);
        end else begin
            q1.push_back(e_wait);
            q2.push_back(e_halt);
        end
    endtask

    task automatic drive(input logic s, input logic [2:0] opc, input logic [1:0] o);
        bus1.s = s; bus1.opcode = opc; bus1.op = o;
        bus2.s = s; bus2.opcode = opc; bus2.op = o;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        if (q1.size() > 0 && q2.size() > 0) begin
            check(tag, obs1(), q1.pop_front());
            check({tag, "_trap"}, obs2(), q2.pop_front());
        end
    endtask

    // Start on the next negedge, drop s after the sampling edge, drain the queues.
    task automatic run_instr(input string tag, input logic [2:0] opc, input logic [1:0] o,
                             input int chg_at, input logic [1:0] chg_op);
        int k;
        push_seq(opc, o);
        @(negedge clk);
        drive(1'b1, opc, o);
        k = 0;
        while (q1.size() > 0 && q2.size() > 0) begin
            step(tag);
            k++;
            if (k == 1) begin bus1.s = 1'b0; bus2.s = 1'b0; end
            if (k == chg_at) begin bus1.op = chg_op; bus2.op = chg_op; end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        e_wait    = mk(1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        e_dec     = mk(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        e_wrimm   = mk(0, 2'b10, 0, 0, 0, 0, 0, 2'b10, 1, 0);
        e_geta    = mk(0, 2'b10, 1, 0, 0, 0, 0, 2'b00, 0, 0);
        e_getb    = mk(0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 0, 0);
        e_alu     = mk(0, 2'b00, 0, 0, 1, 0, 0, 2'b00, 0, 0);
        e_alu_mov = mk(0, 2'b00, 0, 0, 1, 0, 1, 2'b00, 0, 0);
        e_alus    = mk(0, 2'b00, 0, 0, 0, 1, 0, 2'b00, 0, 0);
        e_wrreg   = mk(0, 2'b01, 0, 0, 0, 0, 0, 2'b00, 1, 0);
        e_halt    = mk(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 1);

        rst_n = 1'b0;
        drive(1'b1, 3'b110, 2'b10);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", obs1(), e_wait);
        check("reset_hold_trap", obs2(), e_halt & 16'h0000 | e_wait);
        @(negedge clk);
        drive(1'b0, 3'b000, 2'b00);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push_both(e_wait);
            step("idle");
        end

        run_instr("mov_imm", 3'b110, 2'b10, 0, 2'b00);
        run_instr("mov_reg", 3'b110, 2'b00, 0, 2'b00);
        run_instr("add_opchg", 3'b101, 2'b00, 2, 2'b11);
        run_instr("cmp", 3'b101, 2'b01, 0, 2'b00);
        run_instr("and", 3'b101, 2'b10, 0, 2'b00);
        run_instr("mvn", 3'b101, 2'b11, 0, 2'b00);

        // s held high: second MOV imm starts on the first WAIT cycle.
        push_seq(3'b110, 2'b10);
        push_seq(3'b110, 2'b10);
        @(negedge clk);
        drive(1'b1, 3'b110, 2'b10);
        while (q1.size() > 1 && q2.size() > 1) step("b2b");
        bus1.s = 1'b0; bus2.s = 1'b0;
        step("b2b_end");
        push_both(e_wait);
        step("b2b_idle");

        // Asynchronous reset while an ADD sits in GET_B.
        push_seq(3'b101, 2'b00);
        @(negedge clk);
        drive(1'b1, 3'b101, 2'b00);
        step("add_abort");
        bus1.s = 1'b0; bus2.s = 1'b0;
        step("add_abort");
        step("add_abort");
        q1.delete();
        q2.delete();
        #1 rst_n = 1'b0;
        #1;
        check("abort_rst", obs1(), e_wait);
        check("abort_rst_trap", obs2(), e_wait);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_both(e_wait);
            step("post_abort");
        end

        run_instr("illegal", 3'b000, 2'b00, 0, 2'b00);

        // s ignored while halted; the returning instance runs a MOV imm meanwhile.
        q1.push_back(e_dec);  q2.push_back(e_halt);
        q1.push_back(e_wrimm); q2.push_back(e_halt);
        q1.push_back(e_wait); q2.push_back(e_halt);
        @(negedge clk);
        drive(1'b1, 3'b110, 2'b10);
        step("halt_hold");
        bus1.s = 1'b0; bus2.s = 1'b0;
        step("halt_hold");
        step("halt_hold");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("halt_rst", obs1(), e_wait);
        check("halt_rst_trap", obs2(), e_wait);
        @(negedge clk);
        rst_n = 1'b1;
        push_both(e_wait);
        step("post_halt");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
